// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the 2:1 packet-aware stream multiplexer.
package stream_mux_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_e;

endpackage : stream_mux_pkg

// File: rtl/stream_mux_2x1_if.sv
// Valid/ready stream bundles: source-side (no index) and merged output (with source index).
interface stream_in_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] data;
   logic             last;
   logic             valid;
   logic             ready;

   modport master (output data, output last, output valid, input ready);
   modport slave  (input data, input last, input valid, output ready);
endinterface : stream_in_if

interface stream_out_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] data;
   logic             last;
   logic             sel;
   logic             valid;
   logic             ready;

   modport master (output data, output last, output sel, output valid, input ready);
   modport slave  (input data, input last, input sel, input valid, output ready);
endinterface : stream_out_if

// File: rtl/stream_mux_2x1_arb.sv
// Two-way round-robin arbiter: on a tie the source other than last_grant wins.
module rr_arb_2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant,
   output logic grant_valid
);

   always_comb begin
      grant_valid = req0 || req1;
      if (req0 && req1) begin
         grant = ~last_grant;
      end else begin
         grant = req1;
      end
   end

endmodule : rr_arb_2

// File: rtl/stream_mux_2x1.sv
// 2:1 stream mux that keeps packets contiguous and round-robins between packets.
module stream_mux_2x1
   import stream_mux_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   stream_in_if.slave    in0,
   stream_in_if.slave    in1,
   stream_out_if.master  y
);

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;

   logic [WIDTH-1:0] y_data_q;
   logic             y_last_q;
   logic             y_sel_q;
   logic             y_valid_q;

   logic             load_en;
   logic             arb_grant;
   logic             arb_valid;
   logic             gnt_sel;
   logic             gnt_valid;
   logic             accept;
   logic [WIDTH-1:0] acc_data;
   logic             acc_last;

   assign load_en = !y_valid_q || y.ready;

   rr_arb_2 u_arb (
      .req0        (in0.valid),
      .req1        (in1.valid),
      .last_grant  (last_grant_q),
      .grant       (arb_grant),
      .grant_valid (arb_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (acc_last) begin
                  last_grant_d = gnt_sel;
               end else begin
                  state_d = LOCK;
                  owner_d = gnt_sel;
               end
            end
         end
         LOCK: begin
            if (accept && acc_last) begin
               state_d      = IDLE;
               last_grant_d = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Inside a packet the owner holds the grant even while it has no beat to offer.
   always_comb begin
      gnt_sel   = owner_q;
      gnt_valid = 1'b1;
      if (state_q == IDLE) begin
         gnt_sel   = arb_grant;
         gnt_valid = arb_valid;
      end
      in0.ready = !rst && load_en && gnt_valid && !gnt_sel;
      in1.ready = !rst && load_en && gnt_valid &&  gnt_sel;
      accept    = (in0.ready && in0.valid) || (in1.ready && in1.valid);
      acc_data  = gnt_sel ? in1.data : in0.data;
      acc_last  = gnt_sel ? in1.last : in0.last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_valid_q <= 1'b0;
         y_data_q  <= '0;
         y_last_q  <= 1'b0;
         y_sel_q   <= 1'b0;
      end else if (load_en) begin
         y_valid_q <= accept;
         if (accept) begin
            y_data_q <= acc_data;
            y_last_q <= acc_last;
            y_sel_q  <= gnt_sel;
         end
      end
   end

   assign y.data  = y_data_q;
   assign y.last  = y_last_q;
   assign y.sel   = y_sel_q;
   assign y.valid = y_valid_q;

endmodule : stream_mux_2x1

// File: tb/tb_stream_mux_2x1.sv
// Directed vector bench for stream_mux_2x1: per-cycle table plus a throughput sequence.
module tb_stream_mux_2x1;

   typedef struct {
      logic       rst;
      logic       v0;
      logic [7:0] d0;
      logic       l0;
      logic       v1;
      logic [7:0] d1;
      logic       l1;
      logic       yr;
      logic       r0;
      logic       r1;
      logic       yv;
      logic [7:0] yd;
      logic       yl;
      logic       ys;
   } vec_t;

   localparam int unsigned NVEC = 30;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vecs [NVEC];

   stream_in_if  #(.WIDTH(8)) in0_if ();
   stream_in_if  #(.WIDTH(8)) in1_if ();
   stream_out_if #(.WIDTH(8)) y_if ();

   stream_mux_2x1 #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .in0 (in0_if),
      .in1 (in1_if),
      .y   (y_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(logic rst_v, logic v0, logic [7:0] d0, logic l0,
                               logic v1, logic [7:0] d1, logic l1, logic yr,
                               logic r0, logic r1,
                               logic yv, logic [7:0] yd, logic yl, logic ys);
      vec_t v;
      v.rst = rst_v; v.v0 = v0; v.d0 = d0; v.l0 = l0;
      v.v1 = v1; v.d1 = d1; v.l1 = l1; v.yr = yr;
      v.r0 = r0; v.r1 = r1;
      v.yv = yv; v.yd = yd; v.yl = yl; v.ys = ys;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      in0_if.valid = 1'b0; in0_if.data = '0; in0_if.last = 1'b0;
      in1_if.valid = 1'b0; in1_if.data = '0; in1_if.last = 1'b0;
      y_if.ready = 1'b0;

      //            rst v0 d0     l0 v1 d1     l1 yr  r0 r1  yv yd     yl ys
      vecs[0]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0,  0, 8'h00, 0, 0);
      vecs[1]  = mk(1, 1, 8'hA5, 1, 0, 8'h00, 0, 1,  0, 0,  0, 8'h00, 0, 0);
      vecs[2]  = mk(0, 1, 8'hA5, 1, 0, 8'h00, 0, 1,  1, 0,  1, 8'hA5, 1, 0);
      vecs[3]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0,  0, 8'hA5, 1, 0);
      vecs[4]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0,  0, 8'h00, 0, 0);
      vecs[5]  = mk(0, 1, 8'h11, 1, 1, 8'h22, 1, 1,  1, 0,  1, 8'h11, 1, 0);
      vecs[6]  = mk(0, 1, 8'h11, 1, 1, 8'h22, 1, 1,  0, 1,  1, 8'h22, 1, 1);
      vecs[7]  = mk(0, 1, 8'h11, 1, 1, 8'h22, 1, 1,  1, 0,  1, 8'h11, 1, 0);
      vecs[8]  = mk(0, 1, 8'h11, 1, 1, 8'h22, 1, 1,  0, 1,  1, 8'h22, 1, 1);
      vecs[9]  = mk(0, 1, 8'h01, 0, 1, 8'h33, 1, 1,  1, 0,  1, 8'h01, 0, 0);
      vecs[10] = mk(0, 1, 8'h02, 0, 1, 8'h33, 1, 1,  1, 0,  1, 8'h02, 0, 0);
      vecs[11] = mk(0, 1, 8'h03, 1, 1, 8'h33, 1, 1,  1, 0,  1, 8'h03, 1, 0);
      vecs[12] = mk(0, 0, 8'h00, 0, 1, 8'h33, 1, 1,  0, 1,  1, 8'h33, 1, 1);
      vecs[13] = mk(0, 1, 8'h5A, 1, 0, 8'h00, 0, 1,  1, 0,  1, 8'h5A, 1, 0);
      vecs[14] = mk(0, 1, 8'h77, 1, 1, 8'h66, 1, 0,  0, 0,  1, 8'h5A, 1, 0);
      vecs[15] = mk(0, 1, 8'h77, 1, 1, 8'h66, 1, 0,  0, 0,  1, 8'h5A, 1, 0);
      vecs[16] = mk(0, 1, 8'h77, 1, 1, 8'h66, 1, 0,  0, 0,  1, 8'h5A, 1, 0);
      vecs[17] = mk(0, 1, 8'h77, 1, 1, 8'h66, 1, 0,  0, 0,  1, 8'h5A, 1, 0);
      vecs[18] = mk(0, 1, 8'h77, 1, 1, 8'h66, 1, 1,  0, 1,  1, 8'h66, 1, 1);
      vecs[19] = mk(0, 0, 8'h00, 0, 1, 8'hB1, 0, 1,  0, 1,  1, 8'hB1, 0, 1);
      vecs[20] = mk(0, 1, 8'hC0, 1, 1, 8'hB2, 0, 1,  0, 1,  1, 8'hB2, 0, 1);
      vecs[21] = mk(1, 1, 8'hC0, 1, 1, 8'hB3, 0, 1,  0, 0,  0, 8'h00, 0, 0);
      vecs[22] = mk(0, 1, 8'hC0, 1, 1, 8'hB3, 0, 1,  1, 0,  1, 8'hC0, 1, 0);
      vecs[23] = mk(0, 0, 8'h00, 0, 1, 8'hB3, 0, 1,  0, 1,  1, 8'hB3, 0, 1);
      vecs[24] = mk(0, 1, 8'hC1, 1, 1, 8'hB4, 1, 1,  0, 1,  1, 8'hB4, 1, 1);
      vecs[25] = mk(0, 1, 8'hC1, 1, 0, 8'h00, 0, 1,  1, 0,  1, 8'hC1, 1, 0);
      vecs[26] = mk(0, 0, 8'h00, 0, 1, 8'hD0, 0, 1,  0, 1,  1, 8'hD0, 0, 1);
      vecs[27] = mk(0, 1, 8'hC2, 1, 0, 8'h00, 0, 1,  0, 1,  0, 8'hD0, 0, 1);
      vecs[28] = mk(0, 1, 8'hC2, 1, 1, 8'hD1, 1, 1,  0, 1,  1, 8'hD1, 1, 1);
      vecs[29] = mk(0, 1, 8'hC2, 1, 0, 8'h00, 0, 1,  1, 0,  1, 8'hC2, 1, 0);

      for (int i = 0; i < int'(NVEC); i++) begin
         rst          = vecs[i].rst;
         in0_if.valid = vecs[i].v0; in0_if.data = vecs[i].d0; in0_if.last = vecs[i].l0;
         in1_if.valid = vecs[i].v1; in1_if.data = vecs[i].d1; in1_if.last = vecs[i].l1;
         y_if.ready   = vecs[i].yr;
         #1;
         chk("in0_ready", i, {7'd0, in0_if.ready}, {7'd0, vecs[i].r0});
         chk("in1_ready", i, {7'd0, in1_if.ready}, {7'd0, vecs[i].r1});
         @(posedge clk);
         #1;
         chk("y_valid", i, {7'd0, y_if.valid}, {7'd0, vecs[i].yv});
         chk("y_data",  i, y_if.data, vecs[i].yd);
         chk("y_last",  i, {7'd0, y_if.last}, {7'd0, vecs[i].yl});
         chk("y_sel",   i, {7'd0, y_if.sel},  {7'd0, vecs[i].ys});
      end

      // Both sources stream single-beat packets; last pick was source 0, so source 1 leads.
      begin
         logic exp_sel;
         exp_sel = 1'b1;
         rst = 1'b0;
         in0_if.valid = 1'b1; in0_if.data = 8'hE0; in0_if.last = 1'b1;
         in1_if.valid = 1'b1; in1_if.data = 8'hE1; in1_if.last = 1'b1;
         y_if.ready   = 1'b1;
         for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            chk("tput_valid", 100 + c, {7'd0, y_if.valid}, 8'd1);
            chk("tput_sel",   100 + c, {7'd0, y_if.sel}, {7'd0, exp_sel});
            chk("tput_data",  100 + c, y_if.data, exp_sel ? 8'hE1 : 8'hE0);
            exp_sel = ~exp_sel;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_stream_mux_2x1

// File: doc/stream_mux_2x1.md
STREAM_MUX_2X1 -- requirements
Module: stream_mux_2x1

Interface
REQ-001 Parameter WIDTH, default 8, data width of every channel.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in0_data  input  WIDTH  source 0 beat payload.
REQ-005 in0_last  input  1  source 0 final beat of packet.
REQ-006 in0_valid  input  1  source 0 beat present.
REQ-007 in0_ready  output  1  source 0 beat accepted this cycle when high with in0_valid.
REQ-008 in1_data, in1_last, in1_valid, in1_ready: same widths, directions and meanings for source 1.
REQ-009 y_data  output  WIDTH  merged output payload, registered.
REQ-010 y_last  output  1  merged output end-of-packet, registered.
REQ-011 y_sel  output  1  source index (0/1) of the current output beat, registered.
REQ-012 y_valid  output  1  output beat present, registered.
REQ-013 y_ready  input  1  downstream accepts output beat when high with y_valid.

Function
REQ-014 Transfer on any channel SHALL occur only in a cycle where valid and ready are both high.
REQ-015 load_en SHALL equal (!y_valid || y_ready); no input is accepted when load_en is low.
REQ-016 FSM states SHALL be IDLE and LOCK; owner register (1 bit) and priority pointer last_grant (1 bit) SHALL be held.
REQ-017 IDLE, one source valid: that source is granted; both valid: source != last_grant granted; none valid: no grant.
REQ-018 Granted source k SHALL see ink_ready = load_en combinationally in the same cycle; ungranted source ready SHALL be 0.
REQ-019 IDLE transfer with last=1: stay IDLE, last_grant <= k; with last=0: go LOCK, owner <= k.
REQ-020 LOCK: only owner is granted regardless of other source valid; ready_owner = load_en; other ready = 0.
REQ-021 LOCK transfer with last=1: go IDLE, last_grant <= owner; otherwise stay LOCK.
REQ-022 Accepted beat SHALL appear on y_data/y_last/y_sel with y_valid=1 on the next cycle (latency 1).
REQ-023 While y_valid=1 and y_ready=0, y_data/y_last/y_sel/y_valid SHALL hold stable.
REQ-024 y_ready=1 with y_valid=1 and no new acceptance: y_valid SHALL drop to 0 next cycle.
REQ-025 Simultaneous output drain and input acceptance SHALL sustain one beat per cycle with no bubble.
REQ-026 Beats of different packets SHALL never interleave on the output.

Reset
REQ-027 rst high at a clock edge: state=IDLE, y_valid=0, y_data=0, y_last=0, y_sel=0, owner=0, last_grant=1 (source 0 favoured first).
REQ-028 While rst is high, in0_ready and in1_ready SHALL be 0.
REQ-029 Reset mid-packet SHALL abandon the packet; no beat held at reset is presented after release.

Structure
REQ-030 Shared package stream_mux_pkg SHALL hold the state enum (IDLE, LOCK) and the WIDTH default constant.
REQ-031 Arbitration SHALL be a sub-module rr_arb_2 (inputs req0, req1, last_grant; output grant index, grant_valid); FSM, output register in stream_mux_2x1.

Verification
REQ-032 Reset release, in0 single beat 0xA5 last=1, y_ready=1 -> next cycle y_valid=1, y_data=0xA5, y_sel=0, y_last=1.
REQ-033 Both valid single-beat from reset, in0=0x11, in1=0x22 held, y_ready=1 -> output order 0x11(sel0), 0x22(sel1), 0x11, 0x22 alternating.
REQ-034 in0 3-beat packet 0x01,0x02,0x03(last) with in1 valid throughout -> in1_ready=0 until 0x03 accepted; in1 beat follows 0x03 immediately.
REQ-035 y_ready=0 for 4 cycles with y_valid=1, data 0x5A -> y_* stable, both in_ready=0; y_ready=1 -> 0x5A consumed, next beat loads same edge.
REQ-036 rst asserted after beat 2 of a 4-beat in1 packet -> next cycle y_valid=0, state IDLE; after release in0 wins tie (last_grant=1).
REQ-037 Continuous valid on both sources, y_ready=1 -> y_valid=1 every cycle, no bubbles, 100% throughput.
